ped_request_conditioner: RTL and testbench
==========================================

Name: ped_request_conditioner

Overview:
- Conditions the raw pedestrian push-button for the traffic-light controller FSM, which sits directly downstream of this block.
- The button arrives through one bit of ui_in and is asynchronous and bouncy.
- The block synchronises it, debounces it against a slow sample tick, generates a one-cycle press pulse, and holds a pending-request flag until the controller acknowledges it.

Parameters:
- SYNC_STAGES, 2, number of synchroniser flops on btn_i (must be ≥2).
- DEBOUNCE_TICKS, 16, consecutive tick samples that must disagree with the stable level before the stable level flips (≥2).
- LONG_TICKS, 1000, tick count for long-press detection; used only when PED_LONGPRESS_EN is defined.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- tick_i  in  1  one-cycle sample strobe from the prescaler (e.g. 1 kHz); the debounce state advances only on cycles with tick_i=1.
- btn_i  in  1  raw asynchronous button, active-high.
- ack_i  in  1  one-cycle pulse from the controller: pending request consumed.
- btn_level_o  out  1  debounced stable button level.
- press_o  out  1  one-cycle pulse on a debounced 0→1 transition.
- req_o  out  1  latched pending pedestrian request.
- long_o  out  1  one-cycle long-press pulse (only with PED_LONGPRESS_EN; tied 0 otherwise).

Behaviour:
- One clock, clk. rst is synchronous and active-high.
- Reset: all synchroniser flops, stable level, debounce counter, btn_level_o, press_o, req_o and long_o are cleared to 0. Reset asserted mid-operation discards any pending request and in-progress count.
- Synchroniser: btn_i passes through SYNC_STAGES flops. The last flop is sync.
- Debounce counter width is $clog2(DEBOUNCE_TICKS). It changes only on tick_i=1:
  - sync==stable: cnt<=0.
  - sync!=stable and cnt==DEBOUNCE_TICKS-1: stable<=sync, cnt<=0.
  - otherwise: cnt<=cnt+1.
  - With tick_i=0, cnt and stable hold.
- btn_level_o is the stable register directly.
- Bounce rule: any sample agreeing with stable before the count completes restarts the count. Glitches shorter than DEBOUNCE_TICKS ticks are invisible.
- press_o is registered. It is set on the same edge that stable goes 0→1 and clears on the next edge. A 1→0 transition of stable produces no pulse.
- Latency with tick_i tied 1: press_o is high exactly SYNC_STAGES+DEBOUNCE_TICKS edges after the first edge that samples btn_i=1.
- Request latch:
  - The edge setting press_o also sets req_o.
  - ack_i=1 with no simultaneous press clears req_o on the next edge.
  - Simultaneous press and ack_i: req_o stays 1, so the new press is never lost.
  - ack_i while req_o=0 is ignored.
  - Repeated presses while req_o=1 leave req_o at 1; requests do not queue.
- Button held through reset release: stable starts at 0, so a press and request are generated after the normal debounce latency.

Optional Feature:
- Macro PED_LONGPRESS_EN.
- Defined:
  - A hold counter of $clog2(LONG_TICKS+1) bits clears while stable=0.
  - While stable=1 it increments on each tick, saturating.
  - long_o pulses for one cycle on the edge the counter reaches LONG_TICKS.
  - It pulses once per hold and does not affect req_o.
- Undefined: no hold counter is built and long_o is a constant 0.

Decomposition:
- Package ped_pkg holds the default constants (PED_SYNC_STAGES=2, PED_DEBOUNCE_TICKS=16, PED_LONG_TICKS=1000) and the debounce counter width function/localparam.
- One natural sub-module is sync_ff: a parameterised SYNC_STAGES-deep synchroniser. It is reused elsewhere for other ui_in bits.
- The debounce, request and long-press logic stays in ped_request_conditioner.

Test Plan:
All scenarios use SYNC_STAGES=2 and DEBOUNCE_TICKS=4. LONG_TICKS=10 applies only to scenario 5.
1. Clean press, tick_i=1: btn_i 0→1 held → press_o high exactly 6 edges after the first sampling edge, for 1 cycle; btn_level_o=1 and req_o=1 from that edge.
2. Bounce, tick_i=1: btn_i high 3 cycles, low 1, high 2, then low → press_o never asserts; btn_level_o stays 0; req_o stays 0.
3. Handshake: after scenario 1, pulse ack_i for 1 cycle → req_o=0 next edge. A second debounced press then ack_i in the same cycle as press_o → req_o=1 afterwards.
4. Tick gating, tick_i every 4th cycle: held press → press_o after 2 sync edges plus 4 ticks. No state change occurs on non-tick cycles.
5. PED_LONGPRESS_EN defined, LONG_TICKS=10, tick_i=1: hold 20 cycles → exactly one long_o pulse, 10 ticks after btn_level_o rises. With the macro undefined, long_o is always 0.
6. Reset mid-count: assert rst for 1 cycle at cnt=2 with req_o=1 → all outputs 0 next edge. With btn still held, press_o re-asserts 6 edges after rst deasserts.

Source files
------------

// File: rtl/ped_pkg.sv
// ped_pkg
// Shared defaults for the pedestrian request conditioner and its
// synchroniser, plus the width helper for the debounce counter.
// Contents:
//   PED_SYNC_STAGES    - default synchroniser depth
//   PED_DEBOUNCE_TICKS - default debounce length in sample ticks
//   PED_LONG_TICKS     - default long-press length in sample ticks
//   ped_cnt_width()    - counter width for a given tick count
package ped_pkg;

  localparam int PED_SYNC_STAGES    = 2;
  localparam int PED_DEBOUNCE_TICKS = 16;
  localparam int PED_LONG_TICKS     = 1000;

  // Never return 0 so a counter always has at least one bit.
  function automatic int ped_cnt_width(input int ticks);
    return (ticks <= 2) ? 1 : $clog2(ticks);
  endfunction

  localparam int PED_DEB_CNT_W = ped_cnt_width(PED_DEBOUNCE_TICKS);

endpackage

// File: rtl/sync_ff.sv
// sync_ff
// Multi-flop synchroniser for a single asynchronous input bit. Also used
// for the other ui_in bits, so keep it generic.
// Ports:
//   clk  in  system clock
//   rst  in  synchronous active-high reset, clears every stage
//   d_i  in  asynchronous input
//   q_o  out synchronised output (last stage)
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] r_sync;

  always_ff @(posedge clk) begin
    if (rst) r_sync <= '0;
    else     r_sync <= {r_sync[STAGES-2:0], d_i};
  end

  assign q_o = r_sync[STAGES-1];

endmodule

// File: rtl/ped_request_conditioner.sv
// ped_request_conditioner
// Conditions the raw pedestrian button for the traffic-light controller:
// synchronise, debounce on the slow sample tick, emit a one-cycle press
// pulse and hold a pending request until the controller acknowledges it.
// Optional long-press detection is built when PED_LONGPRESS_EN is defined;
// otherwise long_o is tied low and no hold counter exists.
// Ports:
//   clk          in  system clock
//   rst          in  synchronous active-high reset
//   tick_i       in  sample strobe; debounce/hold state advances only here
//   btn_i        in  raw asynchronous button, active-high
//   ack_i        in  controller consumed the pending request
//   btn_level_o  out debounced stable level
//   press_o      out one-cycle pulse on a debounced rising edge
//   req_o        out latched pending request
//   long_o       out one-cycle long-press pulse (0 unless PED_LONGPRESS_EN)
module ped_request_conditioner
  import ped_pkg::*;
#(
  parameter int SYNC_STAGES    = PED_SYNC_STAGES,
  parameter int DEBOUNCE_TICKS = PED_DEBOUNCE_TICKS,
  parameter int LONG_TICKS     = PED_LONG_TICKS
) (
  input  logic clk,
  input  logic rst,
  input  logic tick_i,
  input  logic btn_i,
  input  logic ack_i,
  output logic btn_level_o,
  output logic press_o,
  output logic req_o,
  output logic long_o
);

  localparam int                CNT_W   = ped_cnt_width(DEBOUNCE_TICKS);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DEBOUNCE_TICKS - 1);

  if (SYNC_STAGES < 2 || DEBOUNCE_TICKS < 2 || LONG_TICKS < 1) begin : g_bad_param
    $error("ped_request_conditioner: illegal parameter value");
  end

  logic             w_sync;
  logic             w_rise;
  logic             r_stable;
  logic [CNT_W-1:0] r_cnt;
  logic             r_press;
  logic             r_req;

  sync_ff #(.STAGES(SYNC_STAGES)) u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (btn_i),
    .q_o (w_sync)
  );

  // The sample that completes the count on a low stable level is the rise.
  assign w_rise = tick_i & w_sync & ~r_stable & (r_cnt == CNT_MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stable <= 1'b0;
      r_cnt    <= '0;
      r_press  <= 1'b0;
      r_req    <= 1'b0;
    end else begin
      r_press <= w_rise;
      if (tick_i) begin
        if (w_sync == r_stable) begin
          r_cnt <= '0;
        end else if (r_cnt == CNT_MAX) begin
          r_stable <= w_sync;
          r_cnt    <= '0;
        end else begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end
      // A press wins over a coincident ack so a new press is never lost.
      if (w_rise)     r_req <= 1'b1;
      else if (ack_i) r_req <= 1'b0;
    end
  end

  assign btn_level_o = r_stable;
  assign press_o     = r_press;
  assign req_o       = r_req;

`ifdef PED_LONGPRESS_EN
  localparam int             LONG_W   = $clog2(LONG_TICKS + 1);
  localparam logic [LONG_W-1:0] LONG_MAX = LONG_W'(LONG_TICKS);
  localparam logic [LONG_W-1:0] LONG_PRE = LONG_W'(LONG_TICKS - 1);

  logic [LONG_W-1:0] r_hold;
  logic              r_long;

  // Saturating at LONG_TICKS gives exactly one pulse per hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hold <= '0;
      r_long <= 1'b0;
    end else begin
      r_long <= 1'b0;
      if (!r_stable) begin
        r_hold <= '0;
      end else if (tick_i && (r_hold != LONG_MAX)) begin
        r_hold <= r_hold + LONG_W'(1);
        if (r_hold == LONG_PRE) r_long <= 1'b1;
      end
    end
  end

  assign long_o = r_long;
`else
  assign long_o = 1'b0;
`endif

endmodule

// File: tb/tb_ped_request_conditioner.sv
module tb_ped_request_conditioner;

  logic clk;
  logic rst;
  logic tick_i;
  logic btn_i;
  logic ack_i;
  logic btn_level_o;
  logic press_o;
  logic req_o;
  logic long_o;

  int n_checks = 0;
  int n_errors = 0;

  ped_request_conditioner #(
    .SYNC_STAGES    (2),
    .DEBOUNCE_TICKS (4),
    .LONG_TICKS     (10)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .tick_i      (tick_i),
    .btn_i       (btn_i),
    .ack_i       (ack_i),
    .btn_level_o (btn_level_o),
    .press_o     (press_o),
    .req_o       (req_o),
    .long_o      (long_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one edge; inputs are driven and outputs sampled 1 ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Release the button and let the stable level fall; no pulse allowed.
  task automatic release_btn(input string tag);
    btn_i = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      chk({tag, "_fall_press"}, press_o, 0);
    end
    chk({tag, "_fall_level"}, btn_level_o, 0);
  endtask

  int long_cnt;
  int long_at;

  initial begin
    rst = 1'b1; tick_i = 1'b1; btn_i = 1'b0; ack_i = 1'b0;
    step(); step();
    rst = 1'b0;
    chk("rst_level", btn_level_o, 0);
    chk("rst_press", press_o, 0);
    chk("rst_req",   req_o, 0);
    chk("rst_long",  long_o, 0);

    // Scenario 1: clean press, press exactly 6 edges after first sample.
    btn_i = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      step();
      chk("s1_press_early", press_o, 0);
      chk("s1_level_early", btn_level_o, 0);
    end
    step();
    chk("s1_press_edge6", press_o, 1);
    chk("s1_level_edge6", btn_level_o, 1);
    chk("s1_req_edge6",   req_o, 1);
    step();
    chk("s1_press_1cyc", press_o, 0);
    chk("s1_req_hold",   req_o, 1);

    // Scenario 3a: ack clears request; ack with no request is ignored.
    ack_i = 1'b1;
    step();
    ack_i = 1'b0;
    chk("s3_ack_clear", req_o, 0);
    ack_i = 1'b1;
    step();
    ack_i = 1'b0;
    chk("s3_ack_idle", req_o, 0);
    release_btn("s1");

    // Scenario 2: bounce 3 high, 1 low, 2 high, then low.
    for (int i = 0; i < 14; i++) begin
      btn_i = (i < 3 || i == 4 || i == 5) ? 1'b1 : 1'b0;
      step();
      chk("s2_press", press_o, 0);
      chk("s2_level", btn_level_o, 0);
    end
    chk("s2_req", req_o, 0);

    // Scenario 3b: ack arrives on the same edge that sets press_o.
    btn_i = 1'b1;
    for (int i = 1; i <= 5; i++) step();
    chk("s3_pre_req", req_o, 0);
    ack_i = 1'b1;
    step();
    ack_i = 1'b0;
    chk("s3_sim_press", press_o, 1);
    chk("s3_sim_req",   req_o, 1);
    step();
    chk("s3_sim_req_after", req_o, 1);
    ack_i = 1'b1;
    step();
    ack_i = 1'b0;
    chk("s3_second_ack", req_o, 0);
    release_btn("s3");

    // Scenario 4: tick on every 4th edge; rise on edge 16.
    btn_i = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      tick_i = (k % 4 == 0) ? 1'b1 : 1'b0;
      step();
      chk("s4_press_early", press_o, 0);
      chk("s4_level_early", btn_level_o, 0);
    end
    tick_i = 1'b1;
    step();
    chk("s4_press_edge16", press_o, 1);
    chk("s4_level_edge16", btn_level_o, 1);
    chk("s4_req_edge16",   req_o, 1);
    ack_i = 1'b1;
    step();
    ack_i = 1'b0;
    chk("s4_ack", req_o, 0);
    release_btn("s4");

    // Scenario 5: long press. Level rises at edge 6, long at edge 16.
    btn_i = 1'b1;
    long_cnt = 0;
    long_at  = -1;
    for (int k = 1; k <= 30; k++) begin
      step();
      if (long_o) begin
        long_cnt++;
        long_at = k;
      end
      if (k == 6) chk("s5_level_edge6", btn_level_o, 1);
    end
`ifdef PED_LONGPRESS_EN
    chk("s5_long_count", long_cnt, 1);
    chk("s5_long_edge",  long_at, 16);
`else
    chk("s5_long_count", long_cnt, 0);
`endif
    chk("s5_req", req_o, 1);
    release_btn("s5");

    // Scenario 6: reset at cnt=2 with a pending request.
    chk("s6_pre_req", req_o, 1);
    btn_i = 1'b1;
    for (int i = 1; i <= 4; i++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("s6_rst_level", btn_level_o, 0);
    chk("s6_rst_press", press_o, 0);
    chk("s6_rst_req",   req_o, 0);
    chk("s6_rst_long",  long_o, 0);
    for (int i = 1; i <= 5; i++) begin
      step();
      chk("s6_press_early", press_o, 0);
      chk("s6_req_early",   req_o, 0);
    end
    step();
    chk("s6_press_edge6", press_o, 1);
    chk("s6_req_edge6",   req_o, 1);
    chk("s6_level_edge6", btn_level_o, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
